mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It executes signed and unsigned multiply and divide over `WIDTH` cycles, one radix-2 step per cycle, and writes a `{hi, lo}` result pair. While it computes, it holds the pipeline through `stallreq`, and it can be flushed with `cancel`. It adds defined multi-cycle timing, signed modes, divide-by-zero handling and cancellation.

---
 rtl/mdu_iter.sv | 179 +++++++++++++++++
 tb/tb_mdu_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit for the EX stage.
//
// One radix-2 step per clock:
//   - Multiply uses shift-add on operand magnitudes.
//   - Divide uses restoring division on operand magnitudes.
//   - Signs are re-applied when the result is written.
// The unit stalls the pipeline while it works and can be flushed at any time.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        begin an operation (sampled in IDLE or DONE)
//   op           00 mult, 01 multu, 10 div, 11 divu
//   src1, src2   multiplicand/dividend and multiplier/divisor, sampled with start
//   cancel       flush: return to IDLE, results untouched
//   busy         high while iterating
//   stallreq     combinational stall request to the pipeline
//   done         one-cycle pulse; hi/lo valid from this cycle
//   hi, lo       {product high, product low} or {remainder, quotient}
//   div_by_zero  last divide had a zero divisor; held until the next accepted start
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier being shifted out / dividend being shifted into quotient.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;   // multiplicand magnitude or divisor magnitude
    logic               is_div;
    logic               neg_q;   // product sign (mult) or quotient sign (div)
    logic               neg_r;   // remainder sign: follows the dividend

    // ------------------------------------------------------------------
    // Operation acceptance and operand conditioning
    // ------------------------------------------------------------------
    logic             can_start, accept, is_signed, dz;
    logic [WIDTH-1:0] abs1, abs2;

    assign can_start = (state == IDLE) || (state == DONE);
    assign accept    = start && !cancel && can_start;
    assign is_signed = ~op[0];
    assign dz        = op[1] && (src2 == '0);
    assign abs1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
    assign abs2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_step;
    logic               last;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right, keeping the carry.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and try to subtract.
    // A borrow (diff[WIDTH]) means the trial failed, so the shifted value is restored.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                        acc[WIDTH-2:0], ~div_diff[WIDTH]};

    assign acc_step = is_div ? div_next : mul_next;
    assign last     = (state == BUSY) && (cnt == LAST);

    // ------------------------------------------------------------------
    // Final signed result, computed from the last step
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    assign prod_fin = neg_q ? -acc_step : acc_step;
    assign quo      = acc_step[WIDTH-1:0];
    assign rem      = acc_step[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? (neg_q ? -quo : quo) : prod_fin[WIDTH-1:0];
    assign res_hi   = is_div ? (neg_r ? -rem : rem) : prod_fin[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt
        // unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = dz ? DONE : BUSY;
            BUSY: if (last)   state_nxt = DONE;
            DONE: begin
                if (accept) state_nxt = dz ? DONE : BUSY;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (cancel) state_nxt = IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            mag_b       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (cancel) begin
            // Flush: drop the operation, keep the last published result.
            cnt <= '0;
        end else if (accept) begin
            cnt         <= '0;
            div_by_zero <= dz;
            is_div      <= op[1];
            neg_q       <= is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
            neg_r       <= is_signed && src1[WIDTH-1];
            // Multiply shifts the multiplier out of the low half;
            // divide shifts the dividend out of the low half.
            acc         <= {{WIDTH{1'b0}}, op[1] ? abs1 : abs2};
            mag_b       <= op[1] ? abs2 : abs1;
            if (dz) begin
                hi <= src1;
                lo <= '1;
            end
        end else if (state == BUSY) begin
            acc <= acc_step;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state == BUSY);
    assign done     = (state == DONE);
    assign stallreq = ~rst & ~cancel & ((start & can_start) | (state == BUSY));

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a 32-bit instance driven from a vector
// table plus hand-written cancel/reset/ignored-start sequences, and an 8-bit
// instance for the narrow-width corners.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, cancel;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        busy, stallreq, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, stall8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy), .stallreq(stallreq), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .src1(a8), .src2(b8),
        .cancel(cancel), .busy(busy8), .stallreq(stall8), .done(done8),
        .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
        int          elat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance to just after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present one operation in the current cycle and wait for done.
    // Returns in the done cycle with start low.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls);
        op = o; src1 = a; src2 = b; start = 1'b1;
        #1;
        stalls = stallreq ? 1 : 0;
        tick();
        start = 1'b0;
        #1;
        lat = 1;
        if (!done) check("dbz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
        while (!done && lat < 100) begin
            if (stallreq) stalls++;
            tick();
            lat++;
        end
        check("stall_low_in_done", {63'd0, stallreq}, 64'd0);
    endtask

    task automatic run8(input string name, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo,
                        input int elat);
        int lat;
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_hi"},  {56'd0, hi8}, {56'd0, ehi});
        check({name, "_lo"},  {56'd0, lo8}, {56'd0, elo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stalls, pulses;

        //          op     a             b             ehi           elo           dbz  lat
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[5]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
        vecs[6]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};

        rst = 1'b1; cancel = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) tick();
        check("stall_in_reset", {63'd0, stallreq}, 64'd0);
        rst = 1'b0;
        #1;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_flags", {60'd0, busy, done, div_by_zero, stallreq}, 64'd0);

        // Table: each vector starts in the done cycle of the previous one.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls);
            check($sformatf("v%0d_lat", i),    64'(lat),    64'(vecs[i].elat));
            check($sformatf("v%0d_stalls", i), 64'(stalls), 64'(vecs[i].elat));
            check($sformatf("v%0d_hi", i),     {32'd0, hi}, {32'd0, vecs[i].ehi});
            check($sformatf("v%0d_lo", i),     {32'd0, lo}, {32'd0, vecs[i].elo});
            check($sformatf("v%0d_dbz", i),    {63'd0, div_by_zero}, {63'd0, vecs[i].edbz});
        end
        tick();
        check("done_one_cycle", {62'd0, done, busy}, 64'd0);

        // Establish hi/lo = 1/2 with divu 5/2.
        run_op(2'b11, 32'd5, 32'd2, lat, stalls);
        check("prior_hi", {32'd0, hi}, 64'd1);
        check("prior_lo", {32'd0, lo}, 64'd2);
        tick();

        // Cancel at iteration 10 (start held with it must also be dropped).
        op = 2'b00; src1 = 32'd3; src2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("busy_before_cancel", {63'd0, busy}, 64'd1);
        cancel = 1'b1; start = 1'b1;
        #1;
        check("stall_during_cancel", {63'd0, stallreq}, 64'd0);
        tick();
        cancel = 1'b0; start = 1'b0;
        #1;
        check("cancel_idle", {62'd0, busy, done}, 64'd0);
        check("cancel_hi", {32'd0, hi}, 64'd1);
        check("cancel_lo", {32'd0, lo}, 64'd2);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done || busy) pulses++;
        end
        check("no_done_after_cancel", 64'(pulses), 64'd0);

        // start together with cancel in IDLE is dropped.
        start = 1'b1; cancel = 1'b1;
        #1;
        check("idle_cancel_stall", {63'd0, stallreq}, 64'd0);
        tick();
        start = 1'b0; cancel = 1'b0;
        #1;
        check("idle_cancel_dropped", {63'd0, busy}, 64'd0);

        // start while BUSY is ignored: multu 3*3 must finish on time with 9.
        op = 2'b01; src1 = 32'd3; src2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (5) begin tick(); lat++; end
        op = 2'b11; src1 = 32'd100; src2 = 32'd0; start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        #1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("busy_start_lat", 64'(lat), 64'd33);
        check("busy_start_hi", {32'd0, hi}, 64'd0);
        check("busy_start_lo", {32'd0, lo}, 64'd9);
        check("busy_start_dbz", {63'd0, div_by_zero}, 64'd0);
        tick();

        // rst at iteration 5.
        op = 2'b01; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("stall_at_rst", {63'd0, stallreq}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        check("rst_mid_flags", {60'd0, busy, done, div_by_zero, stallreq}, 64'd0);

        // Narrow width.
        run8("w8_multu", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01, 9);
        tick();
        run8("w8_div_ovf", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, 9);
        check("w8_dbz", {63'd0, dbz8}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
